// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the head of the fetch stage.
// The next PC comes from one of five sources: sequential, relative branch,
// absolute jump, call (which pushes PC+1) and return (which pops a circular
// return-address stack).
//
// Optional build macro: PC_SEQ_RAS_ERR_EN
//   When defined, the module has an extra output, ras_err. It is a sticky flag
//   that records a RAS underflow (ret on an empty stack) or a RAS overflow
//   (call on a full stack without a simultaneous ret). Only reset clears it.
//   When undefined, the port is absent and both cases are handled silently.

module pc_sequencer #(
  parameter int unsigned           WIDTH     = 16,
  parameter int unsigned           RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]      RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [WIDTH-1:0]               sign_imm,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [WIDTH-1:0]               jump_target,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus1,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
`ifdef PC_SEQ_RAS_ERR_EN
  output logic                           ras_full,
  output logic                           ras_err
`else
  output logic                           ras_full
`endif
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_next;
  logic [PW-1:0]    ptr_top;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] ras_top;
  logic             do_pop;
  logic             do_push;

  // ptr points at the next free slot, so the top entry sits one slot below it.
  // Because the depth is a power of two, the pointer wraps on its own.
  assign ptr_top  = ptr_q - PW'(1);
  assign ras_top  = ras_mem[ptr_top];

  assign pc        = pc_q;
  assign pc_plus1  = pc_q + WIDTH'(1);
  assign ras_count = count_q;

  // The flags are decoded from the registered count, so they have no path from the inputs.
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));

  // A return is taken only when the stack holds an entry. A return has
  // priority over a call, so when both are asserted the call pushes nothing.
  assign do_pop  = !stall && ret && !ras_empty;
  assign do_push = !stall && call && !do_pop;

  // Select the next PC and the next stack pointer/count; stall holds every value.
  always_comb begin
    pc_next    = pc_q;
    ptr_next   = ptr_q;
    count_next = count_q;
    if (!stall) begin
      if (do_pop) begin
        pc_next    = ras_top;
        ptr_next   = ptr_top;
        count_next = count_q - CW'(1);
      end else if (call) begin
        pc_next  = jump_target;
        ptr_next = ptr_q + PW'(1);
        // On a full stack the push overwrites the oldest entry, so the count saturates.
        if (!ras_full) begin
          count_next = count_q + CW'(1);
        end
      end else if (jump) begin
        pc_next = jump_target;
      end else if (branch_taken) begin
        pc_next = pc_plus1 + sign_imm;
      end else begin
        pc_next = pc_plus1;
      end
    end
  end

  // PC, stack pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_next;
      ptr_q   <= ptr_next;
      count_q <= count_next;
    end
  end

  // Stack storage has no reset because its contents are ignored until they are written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ptr_q] <= pc_plus1;
    end
  end

`ifdef PC_SEQ_RAS_ERR_EN
  logic ras_err_q;

  assign ras_err = ras_err_q;

  // Sticky error flag: set by underflow, or by overflow when no ret is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_err_q <= 1'b0;
    end else if (!stall && ((ret && ras_empty) || (call && ras_full && !ret))) begin
      ras_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (WIDTH=16, RAS_DEPTH=4, RESET_PC=0).
`timescale 1ns/1ps

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] sign_imm;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
`ifdef PC_SEQ_RAS_ERR_EN
  logic        ras_err;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .sign_imm(sign_imm), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .pc(pc), .pc_plus1(pc_plus1),
    .ras_count(ras_count), .ras_empty(ras_empty),
`ifdef PC_SEQ_RAS_ERR_EN
    .ras_full(ras_full), .ras_err(ras_err)
`else
    .ras_full(ras_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_ctl();
    stall = 0; branch_taken = 0; sign_imm = '0; jump = 0;
    call = 0; ret = 0; jump_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_ctl();
  endtask

  task automatic do_jump(input logic [15:0] t);
    jump = 1; jump_target = t;
    step();
  endtask

  task automatic do_call(input logic [15:0] t);
    call = 1; jump_target = t;
    step();
  endtask

  task automatic test_reset();
    reset = 1; idle_ctl();
    #2;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_count !== 3'd0) begin
      errors++; $display("FAIL reset_ras: empty=%b full=%b count=%0d want 1 0 0", ras_empty, ras_full, ras_count);
    end
    checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus1: got %h want 0001", pc_plus1); end
`ifdef PC_SEQ_RAS_ERR_EN
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ras_err); end
`endif
    step();
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 16'(i)) begin errors++; $display("FAIL idle_seq%0d: got %h want %h", i, pc, 16'(i)); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL idle_empty: got %b want 1", ras_empty); end
    #3; reset = 1; #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_reset: got %h want 0000", pc); end
    #1; reset = 0;
  endtask

  task automatic test_branch_stall();
    do_jump(16'h0010);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL jump_0010: got %h want 0010", pc); end
    branch_taken = 1; sign_imm = 16'hFFF0;
    step();
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL branch_neg: got %h want 0001", pc); end
    branch_taken = 1; sign_imm = 16'h0005;
    step();
    checks++; if (pc !== 16'h0007) begin errors++; $display("FAIL branch_pos: got %h want 0007", pc); end
    do_jump(16'hFFFF);
    checks++; if (pc_plus1 !== 16'h0000) begin errors++; $display("FAIL plus1_wrap: got %h want 0000", pc_plus1); end
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h want 0000", pc); end
    stall = 1; branch_taken = 1; sign_imm = 16'h0040;
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL stall_branch: got %h want 0000", pc); end
    stall = 1; call = 1; jump_target = 16'h0999;
    step();
    checks++; if (pc !== 16'h0000 || ras_count !== 3'd0) begin
      errors++; $display("FAIL stall_call: pc=%h count=%0d want 0000 0", pc, ras_count);
    end
  endtask

  task automatic test_call_ret();
    do_jump(16'h0020);
    do_call(16'h0100);
    checks++; if (pc !== 16'h0100 || ras_count !== 3'd1) begin
      errors++; $display("FAIL call1: pc=%h count=%0d want 0100 1", pc, ras_count);
    end
    for (int i = 0; i < 5; i++) step();
    checks++; if (pc !== 16'h0105) begin errors++; $display("FAIL seq_0105: got %h want 0105", pc); end
    do_call(16'h0200);
    checks++; if (pc !== 16'h0200 || ras_count !== 3'd2) begin
      errors++; $display("FAIL call2: pc=%h count=%0d want 0200 2", pc, ras_count);
    end
    ret = 1; step();
    checks++; if (pc !== 16'h0106) begin errors++; $display("FAIL ret1: got %h want 0106", pc); end
    ret = 1; step();
    checks++; if (pc !== 16'h0021 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL ret2: pc=%h empty=%b want 0021 1", pc, ras_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] tgt [5];
    logic [15:0] exp_ret [4];
    tgt[0] = 16'h001A; tgt[1] = 16'h002A; tgt[2] = 16'h003A; tgt[3] = 16'h004A; tgt[4] = 16'h005A;
    exp_ret[0] = 16'h004B; exp_ret[1] = 16'h003B; exp_ret[2] = 16'h002B; exp_ret[3] = 16'h001B;
    do_jump(16'h000A);
    for (int i = 0; i < 5; i++) begin
      do_call(tgt[i]);
      checks++; if (pc !== tgt[i] || ras_count !== 3'((i < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL ovf_call%0d: pc=%h count=%0d want %h %0d", i, pc, ras_count, tgt[i], (i < 4) ? i + 1 : 4);
      end
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    for (int i = 0; i < 4; i++) begin
      ret = 1; step();
      checks++; if (pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
`ifdef PC_SEQ_RAS_ERR_EN
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", ras_err); end
`endif
  endtask

  task automatic test_underflow();
    ret = 1; jump = 1; jump_target = 16'h0300;
    step();
    checks++; if (pc !== 16'h0300 || ras_count !== 3'd0) begin
      errors++; $display("FAIL underflow: pc=%h count=%0d want 0300 0", pc, ras_count);
    end
  endtask

  task automatic test_ret_call();
    do_jump(16'h004F);
    do_call(16'h0060);
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL rc_push: count=%0d want 1", ras_count); end
    ret = 1; call = 1; jump_target = 16'h0070;
    step();
    checks++; if (pc !== 16'h0050 || ras_count !== 3'd0) begin
      errors++; $display("FAIL ret_call: pc=%h count=%0d want 0050 0", pc, ras_count);
    end
    step();
    checks++; if (pc !== 16'h0051) begin errors++; $display("FAIL rc_after: got %h want 0051", pc); end
  endtask

  task automatic test_err_sticky_reset();
    #3; reset = 1; #1;
    checks++; if (pc !== 16'h0000 || ras_count !== 3'd0) begin
      errors++; $display("FAIL reset2: pc=%h count=%0d want 0000 0", pc, ras_count);
    end
`ifdef PC_SEQ_RAS_ERR_EN
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset2_err: got %b want 0", ras_err); end
`endif
    #1; reset = 0;
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_ret_call();
    test_err_sticky_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the 16-bit datapath.
- Generalises relative branch-target addition (PC+1 + sign-extended immediate) into a full next-PC sequencer.
- Next-PC sources: sequential, relative branch, absolute jump, call, and return via a parametrised return-address stack (RAS).
- Sits at the head of the fetch stage; drives instruction-memory address and the PC+1 value used downstream.

Parameters:
- WIDTH, 16, PC / address / immediate width in bits.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and RAS unchanged this cycle.
- branch_taken  input  1  take relative branch.
- sign_imm  input  WIDTH  signed branch offset (two's complement).
- jump  input  1  absolute jump to jump_target.
- call  input  1  absolute jump to jump_target and push PC+1.
- ret  input  1  pop RAS and jump to the popped address.
- jump_target  input  WIDTH  absolute target for jump/call.
- pc  output  WIDTH  current PC (registered).
- pc_plus1  output  WIDTH  pc + 1, combinational, modulo 2^WIDTH.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_count == 0.
- ras_full  output  1  ras_count == RAS_DEPTH.

Behaviour:
- Reset (async, any time, including mid-operation): pc = RESET_PC, ras_count = 0, RAS pointer = 0. ras_empty = 1, ras_full = 0. RAS contents are don't-care.
- All state updates on the rising edge of clk. One-cycle latency: controls sampled at edge N set pc visible after edge N.
- stall = 1: pc, RAS contents, pointer and count all hold. All other controls are ignored.
- Next-PC priority when not stalled, highest first:
  - ret with RAS non-empty: pc <= top entry; pop.
  - call: pc <= jump_target; push pc_plus1.
  - jump: pc <= jump_target.
  - branch_taken: pc <= pc_plus1 + sign_imm.
  - otherwise: pc <= pc_plus1.
- Arithmetic:
  - All adds are WIDTH-bit, wrapping modulo 2^WIDTH, with no overflow detection.
  - pc = 2^WIDTH-1 wraps to 0.
  - sign_imm is already WIDTH bits signed; no further extension.
- ret with RAS empty: ignored as a return. Selection falls through to the lower priorities (call/jump/branch/sequential). No pop; count stays 0.
- call with RAS full: circular overwrite of the oldest entry. Pointer advances; count stays RAS_DEPTH.
- ret and call in the same cycle (RAS non-empty): ret wins; call is ignored (no push). Net count is -1.
- RAS organisation: circular buffer with a top pointer.
  - Push writes to ptr, then ptr+1.
  - Pop reads ptr-1, then ptr-1.
  - Pointer wraps modulo RAS_DEPTH.
- ras_empty and ras_full are decoded from the registered count; no combinational path from inputs.

Optional Feature:
- Macro: PC_SEQ_RAS_ERR_EN.
- Defined:
  - Adds output ras_err (1 bit), sticky, reset to 0.
  - Set on any non-stalled cycle with ret while ras_empty = 1 (underflow), or with call while ras_full = 1 (overflow, unless ret is also asserted).
  - Cleared only by reset.
- Undefined: port absent; underflow/overflow behave as above, silently.

Test Plan (WIDTH = 16, RAS_DEPTH = 4, RESET_PC = 0):
- Reset then 3 idle cycles -> pc = 0x0000, 0x0001, 0x0002, 0x0003; ras_empty = 1. Assert reset mid-cycle at pc = 0x0003 -> pc = 0x0000 immediately, without waiting for a clock edge.
- Branch wrap and stall:
  - At pc = 0x0010, branch_taken = 1, sign_imm = 0xFFF0 (-16) -> pc = 0x0001.
  - At pc = 0xFFFF, idle -> pc = 0x0000.
  - stall = 1 together with branch_taken -> pc unchanged.
- Calls and returns:
  - call to 0x0100 from pc 0x0020, call to 0x0200 from pc 0x0105 -> ras_count = 2.
  - ret -> pc = 0x0106.
  - ret -> pc = 0x0021; ras_empty = 1.
- Overflow:
  - 5 calls from pcs 0x0A, 0x1A, 0x2A, 0x3A, 0x4A -> ras_full = 1, count = 4.
  - 4 rets -> pcs 0x4B, 0x3B, 0x2B, 0x1B.
  - ras_err = 1 if PC_SEQ_RAS_ERR_EN is defined.
- Underflow: ret with RAS empty plus jump = 1 to 0x0300 -> pc = 0x0300, count stays 0.
- Simultaneous ret + call with 1 entry (0x0050) -> pc = 0x0050, count = 0, no push.
